// File: rtl/ring_priority_arbiter_if.sv
// Requester <-> arbiter bundle: level requests and enable in, registered grant,
// grant index and priority pointer out.
interface ring_priority_arbiter_if #(
    parameter int N = 4
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic          enable;
    logic [N-1:0]  req;
    logic [N-1:0]  grant;
    logic          grant_valid;
    logic [IW-1:0] grant_id;
    logic [N-1:0]  ptr;

    // Requester side drives requests and enable, observes the grant.
    modport master (
        output enable, req,
        input  grant, grant_valid, grant_id, ptr
    );

    // Arbiter side.
    modport slave (
        input  enable, req,
        output grant, grant_valid, grant_id, ptr
    );
endinterface

// File: rtl/ring_priority_arbiter.sv
// Round-robin arbiter with a one-hot ring pointer. A grant is held until the
// owner drops its request, or until it has been held MAX_HOLD cycles while
// someone else is waiting; the next owner is picked in the same edge.
module ring_priority_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    ring_priority_arbiter_if.slave    arb
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [N-1:0]  ONE  = N'(1);
    localparam logic [HW-1:0] HMAX = HW'(MAX_HOLD);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state;
    logic [HW-1:0] hold_cnt;
    logic [N-1:0]  grant_q;
    logic [N-1:0]  ptr_q;
    logic [IW-1:0] id_q;
    logic          gv_q;

    logic [N-1:0]  others;
    logic [N-1:0]  cand;
    logic          released;
    logic          timeout;
    logic          found;
    logic [IW-1:0] win;
    logic [N-1:0]  win_oh;
    logic [N-1:0]  win_ptr;
    int            pidx;

    assign arb.grant       = grant_q;
    assign arb.grant_valid = gv_q;
    assign arb.grant_id    = id_q;
    assign arb.ptr         = ptr_q;

    // Candidate set and circular priority scan starting at the pointer bit.
    always_comb begin
        others   = arb.req & ~grant_q;
        released = (arb.req & grant_q) == '0;
        timeout  = (hold_cnt == HMAX) && (|others) && arb.enable;
        cand     = (state == IDLE) ? arb.req : others;
        pidx     = 0;
        for (int i = 0; i < N; i++) begin
            if (ptr_q[i]) pidx = i;
        end
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < N; k++) begin
            if (!found && cand[(pidx + k) % N]) begin
                found = 1'b1;
                win   = IW'((pidx + k) % N);
            end
        end
        win_oh  = ONE << win;
        win_ptr = ONE << ((int'(win) + 1) % N);
    end

    // Grant/pointer state machine; every new grant advances the pointer past the winner.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            grant_q  <= '0;
            gv_q     <= 1'b0;
            id_q     <= '0;
            ptr_q    <= ONE;
            hold_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb.enable && found) begin
                        grant_q  <= win_oh;
                        gv_q     <= 1'b1;
                        id_q     <= win;
                        ptr_q    <= win_ptr;
                        hold_cnt <= HW'(1);
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (released || timeout) begin
                        if (arb.enable && found) begin
                            grant_q  <= win_oh;
                            gv_q     <= 1'b1;
                            id_q     <= win;
                            ptr_q    <= win_ptr;
                            hold_cnt <= HW'(1);
                        end else begin
                            grant_q  <= '0;
                            gv_q     <= 1'b0;
                            id_q     <= '0;
                            hold_cnt <= '0;
                            state    <= IDLE;
                        end
                    end else if (hold_cnt != HMAX) begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ring_priority_arbiter.sv
// Directed scenarios plus randomized traffic, every cycle compared against an
// integer-level reference model of the round-robin rules.
module tb_ring_priority_arbiter;
    localparam int N  = 4;
    localparam int MH = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ring_priority_arbiter_if #(.N(N)) bus ();
    ring_priority_arbiter #(.N(N), .MAX_HOLD(MH)) dut (
        .clk   (clk),
        .reset (reset),
        .arb   (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    // model: owner index (-1 = idle), pointer index, cycles held
    int mg = -1;
    int mp = 0;
    int mh = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] c, input int p);
        for (int k = 0; k < N; k++) begin
            if (c[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic model_step(input logic r, input logic en, input logic [N-1:0] rq);
        logic [N-1:0] oth;
        int w;
        if (r) begin
            mg = -1; mp = 0; mh = 0;
        end else if (mg < 0) begin
            w = pick(rq, mp);
            if (en && w >= 0) begin
                mg = w; mp = (w + 1) % N; mh = 1;
            end
        end else begin
            oth = rq;
            oth[mg] = 1'b0;
            if (!rq[mg] || (mh == MH && oth != 0 && en)) begin
                w = pick(oth, mp);
                if (en && w >= 0) begin
                    mg = w; mp = (w + 1) % N; mh = 1;
                end else begin
                    mg = -1; mh = 0;
                end
            end else if (mh < MH) begin
                mh++;
            end
        end
    endtask

    task automatic cyc(input logic r, input logic en, input logic [N-1:0] rq);
        logic [N-1:0] eg;
        reset      = r;
        bus.enable = en;
        bus.req    = rq;
        @(posedge clk);
        model_step(r, en, rq);
        #1;
        eg = (mg < 0) ? '0 : (N'(1) << mg);
        chk("grant", 32'(bus.grant), 32'(eg));
        chk("grant_valid", 32'(bus.grant_valid), (mg >= 0) ? 32'd1 : 32'd0);
        chk("grant_id", 32'(bus.grant_id), (mg < 0) ? 32'd0 : 32'(mg));
        chk("ptr", 32'(bus.ptr), 32'(N'(1) << mp));
        chk("grant_onehot0", 32'($onehot0(bus.grant)), 32'd1);
    endtask

    initial begin
        reset = 1'b1; bus.enable = 1'b1; bus.req = '0;

        // 1: reset held two cycles with all requests up
        cyc(1, 1, 4'b1111);
        cyc(1, 1, 4'b1111);
        chk("t1_grant", 32'(bus.grant), 32'h0);
        chk("t1_ptr", 32'(bus.ptr), 32'h1);
        chk("t1_gv", 32'(bus.grant_valid), 32'h0);

        // 2: scan from ptr, then release hands over directly
        cyc(0, 1, 4'b1010);
        chk("t2_grant", 32'(bus.grant), 32'h2);
        chk("t2_id", 32'(bus.grant_id), 32'h1);
        chk("t2_ptr", 32'(bus.ptr), 32'h4);
        cyc(0, 1, 4'b1000);
        chk("t2_grant2", 32'(bus.grant), 32'h8);
        chk("t2_id2", 32'(bus.grant_id), 32'h3);
        chk("t2_ptr2", 32'(bus.ptr), 32'h1);

        // 3: everyone requesting -> forced rotation every MAX_HOLD cycles
        cyc(1, 1, 4'b0000);
        for (int i = 0; i < 17; i++) begin
            cyc(0, 1, 4'b1111);
            chk("t3_rot", 32'(bus.grant), 32'(1 << ((i / MH) % N)));
        end

        // 4: sole requester is never preempted
        cyc(1, 1, 4'b0000);
        for (int i = 0; i < 10; i++) begin
            cyc(0, 1, 4'b0100);
            chk("t4_grant", 32'(bus.grant), 32'h4);
            chk("t4_ptr", 32'(bus.ptr), 32'h8);
        end

        // 5: enable gates new grants only
        cyc(1, 1, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 4'b1111);
            chk("t5_nogrant", 32'(bus.grant), 32'h0);
        end
        cyc(0, 1, 4'b1111);
        chk("t5_grant", 32'(bus.grant), 32'h1);
        for (int i = 0; i < 6; i++) begin
            cyc(0, 0, 4'b1111);
            chk("t5_hold", 32'(bus.grant), 32'h1);
        end
        cyc(0, 0, 4'b1110);
        chk("t5_idle", 32'(bus.grant), 32'h0);
        chk("t5_idle_gv", 32'(bus.grant_valid), 32'h0);

        // 6: reset mid-grant
        cyc(1, 1, 4'b0000);
        cyc(0, 1, 4'b0100);
        chk("t6_pre", 32'(bus.grant), 32'h4);
        cyc(1, 1, 4'b0100);
        chk("t6_rst_grant", 32'(bus.grant), 32'h0);
        chk("t6_rst_ptr", 32'(bus.ptr), 32'h1);
        cyc(0, 1, 4'b0100);
        chk("t6_regrant", 32'(bus.grant), 32'h4);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) != 0),
                N'($urandom_range(0, (1 << N) - 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
